alarm_timekeeper: RTL and testbench
===================================

Name: alarm_timekeeper

Overview:
- Upstream stage of the alarm clock's 7-segment display multiplexer.
- Keeps an MM:SS wall time and an MM:SS alarm setpoint in BCD.
- Debounces two user buttons and runs a three-state set-mode FSM.
- Presents four BCD digits plus blink flags to the display stage, and drives the buzzer pin with a square wave while the alarm rings.

Parameters:
- CLK_HZ, 50000000, clk cycles per 1 s tick.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples needed to accept a button level change.
- BUZZ_DIV, 25000, clk cycles per buzz half-period (1 kHz at 50 MHz).
- ALARM_SECONDS, 30, ring duration in ticks; legal range 1..3599.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- btn_mode_n  in  1  raw mode button, active-low, asynchronous to clk.
- btn_inc_n  in  1  raw increment button, active-low, asynchronous to clk.
- disp_bcd  out  16  {min_tens, min_ones, sec_tens, sec_ones}, each nibble 0..9.
- blink  out  2  bit1 = minutes field being edited, bit0 = seconds field being edited.
- mode  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_SEC; 3 is never driven.
- alarm_en  out  1  alarm armed.
- ringing  out  1  alarm currently sounding.
- sec_pulse  out  1  one-cycle pulse on each 1 s tick.
- buzz  out  1  buzzer drive.

Behaviour:
- Reset (rst low, asynchronous, all registers):
  - time = 00:00, alarm = 00:00, alarm_en = 0, mode = RUN, ringing = 0, buzz = 0, sec_pulse = 0, disp_bcd = 0, blink = 0.
  - Prescaler, ring counter and buzz divider are cleared.
  - Debounced button state = released.
  - Reset mid-ring silences the buzzer immediately.
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - tick asserts for one cycle when the count equals CLK_HZ-1, then the count wraps to 0.
  - sec_pulse is the registered tick.
  - First tick occurs CLK_HZ cycles after reset release.
- Time:
  - On tick, sec_ones increments. Carries ripple in BCD: 59 s -> 00 s with minute increment; 59:59 -> 00:00.
  - Timekeeping runs in every mode.
- Buttons:
  - Each button passes through a 2-FF synchroniser.
  - A debounce counter resets whenever the synchronised level equals the debounced state.
  - The debounced state flips once the levels have differed for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a one-cycle pulse on the debounced released->pressed transition. Release generates no event.
  - Holding a button produces exactly one event.
- Press priority, evaluated in this order:
  - While ringing, any press event clears ringing, clears the ring counter and forces buzz to 0 on the next cycle. That press is consumed: no mode change, no increment.
  - If mode and inc events occur in the same cycle, mode wins and inc is dropped.
- FSM (mode events):
  - RUN -> SET_MIN -> SET_SEC -> RUN.
  - SET_SEC -> RUN also sets alarm_en = 1.
- Inc events by mode:
  - RUN: toggles alarm_en.
  - SET_MIN: alarm minutes +1, 59 -> 00.
  - SET_SEC: alarm seconds +1, 59 -> 00.
  - Alarm minute and second fields never carry into each other.
- Trigger:
  - On a tick cycle, the next-state time is compared to the alarm.
  - If they are equal and alarm_en = 1 and ringing = 0, then next cycle ringing = 1 and the ring counter = ALARM_SECONDS.
  - Triggering is allowed in any mode.
  - If an alarm edit and a matching tick occur in the same cycle, the comparison uses the pre-edit alarm value.
- Ringing:
  - Each subsequent tick decrements the ring counter.
  - When the counter reaches 0, ringing clears on the same cycle.
  - Clearing alarm_en while ringing does not stop the ring; only a press or expiry stops it.
- Buzz:
  - While ringing, buzz toggles every BUZZ_DIV cycles. The divider restarts at 0 and buzz starts at 0 when ringing rises.
  - Otherwise buzz = 0.
- Display:
  - disp_bcd shows the registered time in RUN and the alarm value in SET_MIN/SET_SEC, updated every cycle with 1-cycle latency.
  - blink = 2'b10 in SET_MIN, 2'b01 in SET_SEC, 2'b00 in RUN.

Test Plan (CLK_HZ=10, DEBOUNCE_CYCLES=4, BUZZ_DIV=2, ALARM_SECONDS=3):
- Release reset, run 36000 cycles -> disp_bcd steps through 0x0000..0x5959 once per 10 cycles and wraps to 0x0000; sec_pulse pulses 3600 times.
- Pulse btn_mode_n low for 3 cycles, then glitch it low/high every cycle -> no mode change. Hold it low 10 cycles -> exactly one event, mode = 1, blink = 2'b10.
- From reset: mode, inc x2, mode, inc x5, mode -> alarm = 02:05, mode = 0, alarm_en = 1. At time 02:05 -> ringing = 1, buzz toggles every 2 cycles; ringing clears 3 ticks later and buzz holds 0.
- While ringing, press inc -> ringing = 0 and buzz = 0 next cycle; mode and alarm_en are unchanged.
- Press mode and inc in the same cycle (in RUN) -> mode = 1; alarm_en unchanged.
- Assert rst mid-ring with buzz = 1 -> all outputs immediately return to their reset values.

Source files
------------

// File: rtl/alarm_timekeeper.sv
// MM:SS wall clock and alarm setpoint in BCD with debounced buttons, a three-state
// set-mode FSM, ring timer and buzzer square wave feeding the display multiplexer.
module alarm_timekeeper #(
  parameter int CLK_HZ          = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BUZZ_DIV        = 25000,
  parameter int ALARM_SECONDS   = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode_n,
  input  logic        btn_inc_n,
  output logic [15:0] disp_bcd,
  output logic [1:0]  blink,
  output logic [1:0]  mode,
  output logic        alarm_en,
  output logic        ringing,
  output logic        sec_pulse,
  output logic        buzz
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BUZZ_DIV + 1);
  localparam int RW = 12;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BUZZ_MAX  = BW'(BUZZ_DIV - 1);
  localparam logic [RW-1:0] RING_INIT = RW'(ALARM_SECONDS);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_MIN = 2'd1,
    MODE_SET_SEC = 2'd2
  } mode_t;

  // Increment a two-digit BCD field 00..59, wrapping 59 -> 00.
  function automatic logic [7:0] inc_field(input logic [7:0] f);
    logic [7:0] r;
    if (f[3:0] == 4'd9) begin
      if (f[7:4] == 4'd5) r = 8'h00;
      else                r = {f[7:4] + 4'd1, 4'd0};
    end else begin
      r = {f[7:4], f[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [PW-1:0] presc_r;
  logic [1:0]    sync1_r, sync2_r, db_r, press_r;
  logic [DW-1:0] db_cnt_r [2];
  logic [15:0]   time_r, alarm_r, disp_r;
  logic [15:0]   time_n, alarm_n, time_inc_s, disp_n;
  logic [RW-1:0] ring_cnt_r, rcnt_n;
  logic [BW-1:0] bdiv_r, bdiv_n;
  logic [1:0]    blink_r, blink_n;
  mode_t         mode_r, mode_n;
  logic          tick_s, any_press_s;
  logic          alarm_en_r, en_n, ringing_r, ring_n, buzz_r, buzz_n, sec_pulse_r;

  assign tick_s      = (presc_r == PRESC_MAX);
  assign any_press_s = |press_r;
  assign time_inc_s  = {(time_r[7:0] == 8'h59) ? inc_field(time_r[15:8]) : time_r[15:8],
                        inc_field(time_r[7:0])};

  // Prescaler producing the 1 s tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r     <= {PW{1'b0}};
      sec_pulse_r <= 1'b0;
    end else begin
      presc_r     <= tick_s ? {PW{1'b0}} : presc_r + PW'(1);
      sec_pulse_r <= tick_s;
    end
  end

  // Button synchronisers, debouncers and press-event pulses (bit0 mode, bit1 inc).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
      db_r    <= 2'b11;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt_r[i] <= {DW{1'b0}};
    end else begin
      sync1_r <= {btn_inc_n, btn_mode_n};
      sync2_r <= sync1_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == db_r[i]) begin
          db_cnt_r[i] <= {DW{1'b0}};
          press_r[i]  <= 1'b0;
        end else if (db_cnt_r[i] == DEB_MAX) begin
          db_cnt_r[i] <= {DW{1'b0}};
          db_r[i]     <= sync2_r[i];
          press_r[i]  <= ~sync2_r[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
          press_r[i]  <= 1'b0;
        end
      end
    end
  end

  // Next-state logic: time, ring control, mode FSM, alarm edits, buzzer, display.
  always_comb begin
    time_n  = tick_s ? time_inc_s : time_r;
    alarm_n = alarm_r;
    en_n    = alarm_en_r;
    mode_n  = mode_r;
    ring_n  = ringing_r;
    rcnt_n  = ring_cnt_r;
    buzz_n  = 1'b0;
    bdiv_n  = {BW{1'b0}};
    disp_n  = time_r;
    blink_n = 2'b00;

    // The trigger compares against the pre-edit alarm register.
    if (ringing_r && any_press_s) begin
      ring_n = 1'b0;
      rcnt_n = {RW{1'b0}};
    end else if (ringing_r && tick_s) begin
      rcnt_n = ring_cnt_r - RW'(1);
      ring_n = (ring_cnt_r != RW'(1));
    end else if (!ringing_r && tick_s && alarm_en_r && (time_inc_s == alarm_r)) begin
      ring_n = 1'b1;
      rcnt_n = RING_INIT;
    end else begin
      ring_n = ringing_r;
    end

    if (ringing_r && any_press_s) begin
      mode_n = mode_r;
    end else if (press_r[0]) begin
      case (mode_r)
        MODE_RUN:     mode_n = MODE_SET_MIN;
        MODE_SET_MIN: mode_n = MODE_SET_SEC;
        MODE_SET_SEC: begin
          mode_n = MODE_RUN;
          en_n   = 1'b1;
        end
        default:      mode_n = MODE_RUN;
      endcase
    end else if (press_r[1]) begin
      case (mode_r)
        MODE_RUN:     en_n          = ~alarm_en_r;
        MODE_SET_MIN: alarm_n[15:8] = inc_field(alarm_r[15:8]);
        MODE_SET_SEC: alarm_n[7:0]  = inc_field(alarm_r[7:0]);
        default:      en_n          = alarm_en_r;
      endcase
    end else begin
      mode_n = mode_r;
    end

    // Divider and buzz restart from zero on the cycle ringing rises.
    if (!ring_n || !ringing_r) begin
      buzz_n = 1'b0;
      bdiv_n = {BW{1'b0}};
    end else if (bdiv_r == BUZZ_MAX) begin
      buzz_n = ~buzz_r;
      bdiv_n = {BW{1'b0}};
    end else begin
      buzz_n = buzz_r;
      bdiv_n = bdiv_r + BW'(1);
    end

    case (mode_r)
      MODE_RUN: begin
        disp_n  = time_r;
        blink_n = 2'b00;
      end
      MODE_SET_MIN: begin
        disp_n  = alarm_r;
        blink_n = 2'b10;
      end
      MODE_SET_SEC: begin
        disp_n  = alarm_r;
        blink_n = 2'b01;
      end
      default: begin
        disp_n  = time_r;
        blink_n = 2'b00;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_r     <= 16'h0000;
      alarm_r    <= 16'h0000;
      alarm_en_r <= 1'b0;
      mode_r     <= MODE_RUN;
      ringing_r  <= 1'b0;
      ring_cnt_r <= {RW{1'b0}};
      buzz_r     <= 1'b0;
      bdiv_r     <= {BW{1'b0}};
      disp_r     <= 16'h0000;
      blink_r    <= 2'b00;
    end else begin
      time_r     <= time_n;
      alarm_r    <= alarm_n;
      alarm_en_r <= en_n;
      mode_r     <= mode_n;
      ringing_r  <= ring_n;
      ring_cnt_r <= rcnt_n;
      buzz_r     <= buzz_n;
      bdiv_r     <= bdiv_n;
      disp_r     <= disp_n;
      blink_r    <= blink_n;
    end
  end

  assign disp_bcd  = disp_r;
  assign blink     = blink_r;
  assign mode      = mode_r;
  assign alarm_en  = alarm_en_r;
  assign ringing   = ringing_r;
  assign sec_pulse = sec_pulse_r;
  assign buzz      = buzz_r;

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed bench for alarm_timekeeper with small parameters (10 clk per second,
// 4-cycle debounce, buzz half-period 2, 3 s ring).
module tb_alarm_timekeeper;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_mode_n = 1'b1;
  logic        btn_inc_n = 1'b1;
  logic [15:0] disp_bcd;
  logic [1:0]  blink, mode;
  logic        alarm_en, ringing, sec_pulse, buzz;
  int          n_checks = 0;
  int          n_fail = 0;

  alarm_timekeeper #(.CLK_HZ(10), .DEBOUNCE_CYCLES(4), .BUZZ_DIV(2), .ALARM_SECONDS(3)) dut (
    .clk(clk), .rst(rst), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .disp_bcd(disp_bcd), .blink(blink), .mode(mode), .alarm_en(alarm_en),
    .ringing(ringing), .sec_pulse(sec_pulse), .buzz(buzz)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    btn_mode_n = 1'b1;
    btn_inc_n = 1'b1;
    step(2);
    rst = 1'b1;
  endtask

  // mask bit0 = mode button, bit1 = inc button; press then fully release
  task automatic press_btn(input logic [1:0] mask);
    btn_mode_n = ~mask[0];
    btn_inc_n  = ~mask[1];
    step(6);
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    step(7);
  endtask

  task automatic press_n(input logic [1:0] mask, input int n);
    for (int i = 0; i < n; i++) press_btn(mask);
  endtask

  task automatic wait_ringing(input int budget);
    for (int i = 0; i < budget && ringing !== 1'b1; i++) step(1);
    n_checks++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_wait: ringing=%b required 1 within %0d cycles", ringing, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(3);
    n_checks++;
    if ({disp_bcd, blink, mode, alarm_en, ringing, sec_pulse, buzz} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got disp=%h blink=%b mode=%0d en=%b ring=%b sp=%b buzz=%b required all 0",
               disp_bcd, blink, mode, alarm_en, ringing, sec_pulse, buzz);
    end
    rst = 1'b1;
    step(9);
    n_checks++;
    if (sec_pulse !== 1'b0) begin n_fail++; $display("FAIL first_tick_early: sec_pulse=%b required 0", sec_pulse); end
    step(1);
    n_checks++;
    if (sec_pulse !== 1'b1) begin n_fail++; $display("FAIL first_tick: sec_pulse=%b required 1", sec_pulse); end
    step(1);
    n_checks++;
    if (disp_bcd !== 16'h0001) begin n_fail++; $display("FAIL first_second: disp=%h required 0001", disp_bcd); end
  endtask

  task automatic test_timekeeping;
    int pulses = 0;
    logic [15:0] exp_disp;
    apply_reset;
    for (int c = 1; c <= 36005; c++) begin
      step(1);
      if (sec_pulse === 1'b1) pulses++;
      if (c % 10 == 5) begin
        exp_disp = to_bcd(((c - 1) / 10) % 3600);
        n_checks++;
        if (disp_bcd !== exp_disp) begin
          n_fail++;
          $display("FAIL time_disp: cycle %0d disp=%h required %h", c, disp_bcd, exp_disp);
        end
      end
    end
    n_checks++;
    if (pulses != 3600) begin n_fail++; $display("FAIL sec_pulse_count: got %0d required 3600", pulses); end
  endtask

  task automatic test_debounce;
    apply_reset;
    btn_mode_n = 1'b0; step(3);
    btn_mode_n = 1'b1; step(2);
    for (int i = 0; i < 4; i++) begin
      btn_mode_n = 1'b0; step(1);
      btn_mode_n = 1'b1; step(1);
    end
    step(8);
    n_checks++;
    if (mode !== 2'd0 || blink !== 2'b00) begin
      n_fail++;
      $display("FAIL glitch_reject: mode=%0d blink=%b required 0/00", mode, blink);
    end
    btn_mode_n = 1'b0; step(10);
    btn_mode_n = 1'b1; step(8);
    n_checks++;
    if (mode !== 2'd1 || blink !== 2'b10) begin
      n_fail++;
      $display("FAIL hold_one_event: mode=%0d blink=%b required 1/10", mode, blink);
    end
  endtask

  task automatic test_run_inc;
    apply_reset;
    press_btn(2'b10);
    n_checks++;
    if (alarm_en !== 1'b1 || mode !== 2'd0) begin n_fail++; $display("FAIL run_inc_on: en=%b mode=%0d required 1/0", alarm_en, mode); end
    press_btn(2'b10);
    n_checks++;
    if (alarm_en !== 1'b0) begin n_fail++; $display("FAIL run_inc_off: en=%b required 0", alarm_en); end
  endtask

  task automatic test_alarm_wrap;
    apply_reset;
    press_btn(2'b01);
    press_n(2'b10, 59);
    n_checks++;
    if (disp_bcd !== 16'h5900) begin n_fail++; $display("FAIL alarm_min_59: disp=%h required 5900", disp_bcd); end
    press_btn(2'b10);
    n_checks++;
    if (disp_bcd !== 16'h0000) begin n_fail++; $display("FAIL alarm_min_wrap: disp=%h required 0000", disp_bcd); end
    press_btn(2'b10);
    press_btn(2'b01);
    press_n(2'b10, 59);
    n_checks++;
    if (disp_bcd !== 16'h0159 || blink !== 2'b01) begin
      n_fail++;
      $display("FAIL alarm_sec_59: disp=%h blink=%b required 0159/01", disp_bcd, blink);
    end
    press_btn(2'b10);
    n_checks++;
    if (disp_bcd !== 16'h0100) begin n_fail++; $display("FAIL alarm_sec_wrap_no_carry: disp=%h required 0100", disp_bcd); end
  endtask

  task automatic test_alarm_ring;
    logic exp_buzz;
    apply_reset;
    press_btn(2'b01);
    n_checks++;
    if (mode !== 2'd1) begin n_fail++; $display("FAIL set_min_entry: mode=%0d required 1", mode); end
    press_n(2'b10, 2);
    press_btn(2'b01);
    press_n(2'b10, 5);
    n_checks++;
    if (disp_bcd !== 16'h0205 || mode !== 2'd2) begin
      n_fail++;
      $display("FAIL alarm_value: disp=%h mode=%0d required 0205/2", disp_bcd, mode);
    end
    press_btn(2'b01);
    n_checks++;
    if (mode !== 2'd0 || alarm_en !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_on_exit: mode=%0d en=%b required 0/1", mode, alarm_en);
    end
    wait_ringing(2000);
    n_checks++;
    if (sec_pulse !== 1'b1 || buzz !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_rise: sec_pulse=%b buzz=%b required 1/0", sec_pulse, buzz);
    end
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (k == 1) begin
        n_checks++;
        if (disp_bcd !== 16'h0205) begin n_fail++; $display("FAIL ring_time: disp=%h required 0205", disp_bcd); end
      end
      exp_buzz = (k < 30) ? (((k / 2) % 2) == 1) : 1'b0;
      n_checks++;
      if (ringing !== (k < 30) || buzz !== exp_buzz) begin
        n_fail++;
        $display("FAIL ring_buzz: k=%0d ringing=%b buzz=%b required %b/%b", k, ringing, buzz, k < 30, exp_buzz);
      end
    end
    n_checks++;
    if (alarm_en !== 1'b1) begin n_fail++; $display("FAIL en_after_ring: en=%b required 1", alarm_en); end
  endtask

  task automatic test_ring_stop_press;
    apply_reset;
    press_btn(2'b01);
    press_btn(2'b10);
    press_btn(2'b01);
    press_btn(2'b01);
    wait_ringing(1000);
    btn_inc_n = 1'b0;
    step(6);
    n_checks++;
    if (ringing !== 1'b1) begin n_fail++; $display("FAIL ring_before_stop: ringing=%b required 1", ringing); end
    step(1);
    n_checks++;
    if (ringing !== 1'b0 || buzz !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_stop: ringing=%b buzz=%b required 0/0", ringing, buzz);
    end
    btn_inc_n = 1'b1;
    step(7);
    n_checks++;
    if (mode !== 2'd0 || alarm_en !== 1'b1 || ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL press_consumed: mode=%0d en=%b ring=%b required 0/1/0", mode, alarm_en, ringing);
    end
  endtask

  task automatic test_back_to_back;
    press_btn(2'b11);
    n_checks++;
    if (mode !== 2'd1 || alarm_en !== 1'b1 || blink !== 2'b10) begin
      n_fail++;
      $display("FAIL mode_wins: mode=%0d en=%b blink=%b required 1/1/10", mode, alarm_en, blink);
    end
  endtask

  task automatic test_reset_mid_ring;
    apply_reset;
    press_btn(2'b01);
    press_btn(2'b10);
    press_btn(2'b01);
    press_btn(2'b01);
    wait_ringing(1000);
    for (int i = 0; i < 10 && buzz !== 1'b1; i++) step(1);
    n_checks++;
    if (buzz !== 1'b1) begin n_fail++; $display("FAIL buzz_high_wait: buzz=%b required 1", buzz); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({disp_bcd, blink, mode, alarm_en, ringing, sec_pulse, buzz} !== 24'h0) begin
      n_fail++;
      $display("FAIL async_reset_mid_ring: disp=%h blink=%b mode=%0d en=%b ring=%b sp=%b buzz=%b required all 0",
               disp_bcd, blink, mode, alarm_en, ringing, sec_pulse, buzz);
    end
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    test_reset;
    test_timekeeping;
    test_debounce;
    test_run_inc;
    test_alarm_wrap;
    test_alarm_ring;
    test_ring_stop_press;
    test_back_to_back;
    test_reset_mid_ring;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
